// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_adder_pkg;
    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'b00;
    localparam state_t RUN  = 2'b01;
    localparam state_t DONE = 2'b10;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and result bus of the serial adder controller.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit behavioral full adder shared across all bit positions.
module serial_adder_ctrl_fa (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder sequenced LSB-first over WIDTH cycles,
// carry held in a flop between bit positions, registered sum/c_out/ovf.
import serial_adder_pkg::*;

module serial_adder_ctrl #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               w_fa_sum;
    logic               w_fa_cout;
    logic               w_last;
    logic               w_busy;
    logic               w_done;

    serial_adder_ctrl_fa u_fa (
        .x     (r_a[0]),
        .y     (r_b[0]),
        .c_in  (r_carry),
        .sum   (w_fa_sum),
        .c_out (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == RUN);
        w_done = (r_state == DONE);
    end

    // Results are only written on the last bit, so outputs hold through IDLE and RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_carry <= bus.c_in;
                    r_res   <= '0;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    if (w_last) begin
                        r_sum  <= {w_fa_sum, r_res[WIDTH-1:1]};
                        r_cout <= w_fa_cout;
                        // r_carry here is the carry into the MSB
                        r_ovf  <= r_carry ^ w_fa_cout;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = r_sum;
    assign bus.c_out = r_cout;
    assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and swept checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an operation from the current negedge and waits for done (bounded).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output int lat, output int bcnt, output bit held);
        logic [W-1:0] p_sum;
        logic         p_cout;
        logic         p_ovf;
        p_sum  = bus.sum;
        p_cout = bus.c_out;
        p_ovf  = bus.ovf;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.c_in  = ~cin;
        lat  = 0;
        bcnt = 0;
        held = 1'b1;
        while (!bus.done && lat < 20) begin
            if (bus.busy) bcnt++;
            if (bus.sum !== p_sum || bus.c_out !== p_cout || bus.ovf !== p_ovf) held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 8'hAA; bus.b = 8'h55; bus.c_in = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        n_chk++;
        if (bus.sum !== 8'h00 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_result: sum=%h c_out=%b ovf=%b expected 00 0 0", bus.sum, bus.c_out, bus.ovf);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_collision: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_zero();
        int lat, bcnt;
        bit held;
        run_op(8'h00, 8'h00, 1'b0, lat, bcnt, held);
        n_chk++;
        if (lat !== 8) begin
            n_fail++; $display("FAIL zero_latency: got %0d expected 8", lat);
        end
        n_chk++;
        if (bcnt !== 8) begin
            n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 8", bcnt);
        end
        n_chk++;
        if (bus.sum !== 8'h00 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL zero_result: sum=%h c_out=%b ovf=%b expected 00 0 0", bus.sum, bus.c_out, bus.ovf);
        end
        @(negedge clk);
        n_chk++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done_pulse: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_carry_ovf();
        int lat, bcnt;
        bit held;
        logic [W-1:0] va [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h80};
        logic [W-1:0] vb [4] = '{8'h01, 8'h01, 8'hFF, 8'h80};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] es [4] = '{8'h00, 8'h80, 8'hFF, 8'h00};
        logic         eco[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic         eov[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat, bcnt, held);
            n_chk++;
            if (lat !== 8 || bus.sum !== es[i] || bus.c_out !== eco[i] || bus.ovf !== eov[i]) begin
                n_fail++;
                $display("FAIL carry_ovf[%0d]: lat=%0d sum=%h c_out=%b ovf=%b expected 8 %h %b %b",
                         i, lat, bus.sum, bus.c_out, bus.ovf, es[i], eco[i], eov[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int ndone, lat, bcnt;
        bit held;
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.c_in = 1'b0;
        @(negedge clk);
        ndone = 0;
        for (int it = 1; it <= 8; it++) begin
            bus.start = (it == 3);
            bus.a = 8'hFF; bus.b = 8'hFF;
            @(negedge clk);
            if (bus.done) ndone++;
        end
        n_chk++;
        if (ndone !== 1 || bus.sum !== 8'h46) begin
            n_fail++; $display("FAIL ignore_start_run: done_count=%0d sum=%h expected 1 46", ndone, bus.sum);
        end
        bus.start = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start_done: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        run_op(8'hFF, 8'hFF, 1'b0, lat, bcnt, held);
        n_chk++;
        if (lat !== 8 || bus.sum !== 8'hFE || bus.c_out !== 1'b1 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back: lat=%0d sum=%h c_out=%b ovf=%b expected 8 fe 1 0",
                               lat, bus.sum, bus.c_out, bus.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int ndone, lat, bcnt;
        bit held;
        bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h0F; bus.c_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL abort_clear: busy=%b done=%b sum=%h c_out=%b ovf=%b expected 0 0 00 0 0",
                               bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf);
        end
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        n_chk++;
        if (ndone !== 0) begin
            n_fail++; $display("FAIL abort_no_done: activity_cycles=%0d expected 0", ndone);
        end
        run_op(8'h01, 8'h01, 1'b0, lat, bcnt, held);
        n_chk++;
        if (lat !== 8 || bus.sum !== 8'h02 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL abort_restart: lat=%0d sum=%h c_out=%b ovf=%b expected 8 02 0 0",
                               lat, bus.sum, bus.c_out, bus.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bcnt;
        bit held;
        logic [W-1:0] a, b;
        logic         cin;
        logic [W:0]   full;
        logic         eovf;
        for (int i = 0; i < 200; i++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            cin  = 1'($urandom);
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            eovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            run_op(a, b, cin, lat, bcnt, held);
            n_chk++;
            if (lat !== 8 || bus.sum !== full[W-1:0] || bus.c_out !== full[W] || bus.ovf !== eovf) begin
                n_fail++; $display("FAIL random[%0d] %h+%h+%b: lat=%0d sum=%h c_out=%b ovf=%b expected 8 %h %b %b",
                                   i, a, b, cin, lat, bus.sum, bus.c_out, bus.ovf, full[W-1:0], full[W], eovf);
            end
            n_chk++;
            if (held !== 1'b1) begin
                n_fail++; $display("FAIL random_hold[%0d]: outputs changed before done, held=%b expected 1", i, held);
            end
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_carry_ovf();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
